// File: rtl/msi_snoop_cache.sv
// msi_snoop_cache: direct-mapped, write-back, N-line MSI snooping cache.
// One CPU port, one shared memory port, and a request/acknowledge pair of
// coherence channels to the peer cache. Snoops are serviced in IDLE and in
// BUS (while this cache waits on its own coherence message) so that two
// caches waiting on each other cannot deadlock.
module msi_snoop_cache #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic              snp_valid,
    input  logic [1:0]        snp_op,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              snp_ack
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    localparam logic [1:0] OP_RM  = 2'd0;
    localparam logic [1:0] OP_WM  = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;

    typedef enum logic [2:0] {IDLE, BUS, SNP_WB, VICT_WB, FILL, RESP} state_t;
    typedef enum logic [1:0] {LN_I, LN_S, LN_M} line_t;

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;
    line_t               line_st_q [LINES];
    line_t               line_st_d [LINES];
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [TAG_W-1:0]    tag_d [LINES];
    logic [DATA_W-1:0]   data_q [LINES];
    logic [DATA_W-1:0]   data_d [LINES];
    logic                bus_pend_q, bus_pend_d;

    logic                cpu_done_q, cpu_done_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                bus_valid_q, bus_valid_d;
    logic [1:0]          bus_op_q, bus_op_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                snp_ack_q, snp_ack_d;

    logic [INDEX_W-1:0]  cpu_idx, snp_idx;
    logic [TAG_W-1:0]    cpu_tag, snp_tag;
    logic                cpu_hit, snp_hit, snp_take, bus_done, mem_done;

    assign cpu_idx  = cpu_addr[INDEX_W-1:0];
    assign cpu_tag  = cpu_addr[ADDR_W-1:INDEX_W];
    assign snp_idx  = snp_addr[INDEX_W-1:0];
    assign snp_tag  = snp_addr[ADDR_W-1:INDEX_W];
    assign cpu_hit  = (line_st_q[cpu_idx] != LN_I) && (tag_q[cpu_idx] == cpu_tag);
    assign snp_hit  = (line_st_q[snp_idx] != LN_I) && (tag_q[snp_idx] == snp_tag);
    // A snoop is taken only in IDLE/BUS, and never in its own ack cycle.
    assign snp_take = snp_valid && !snp_ack_q && ((state_q == IDLE) || (state_q == BUS));
    // A bus_ack that arrived while a snoop was being serviced is remembered.
    assign bus_done = bus_pend_q || (bus_valid_q && bus_ack);
    assign mem_done = mem_req_q && mem_ack;

    // Next-state, line-array and registered-output computation.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        line_st_d   = line_st_q;
        tag_d       = tag_q;
        data_d      = data_q;
        bus_pend_d  = bus_pend_q;
        cpu_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_valid_d = bus_valid_q;
        bus_op_d    = bus_op_q;
        bus_addr_d  = bus_addr_q;
        snp_ack_d   = 1'b0;

        // bus_valid drops the cycle after bus_ack regardless of what the FSM is doing.
        if (bus_valid_q && bus_ack) begin
            bus_valid_d = 1'b0;
            bus_pend_d  = 1'b1;
        end

        if (snp_take) begin
            ret_d = state_q;
            if (snp_hit && (line_st_q[snp_idx] == LN_M) &&
                ((snp_op == OP_RM) || (snp_op == OP_WM))) begin
                state_d     = SNP_WB;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = {tag_q[snp_idx], snp_idx};
                mem_wdata_d = data_q[snp_idx];
            end else begin
                // S hit (any op), M hit with INV (protocol error), or miss.
                if (snp_hit && (snp_op != OP_RM)) begin
                    line_st_d[snp_idx] = LN_I;
                end
                snp_ack_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        if (cpu_hit && !cpu_we) begin
                            state_d     = RESP;
                            cpu_done_d  = 1'b1;
                            cpu_rdata_d = data_q[cpu_idx];
                        end else if (cpu_hit && (line_st_q[cpu_idx] == LN_M)) begin
                            data_d[cpu_idx] = cpu_wdata;
                            state_d         = RESP;
                            cpu_done_d      = 1'b1;
                        end else begin
                            state_d     = BUS;
                            bus_valid_d = 1'b1;
                            bus_addr_d  = cpu_addr;
                            if (cpu_hit) begin
                                bus_op_d = OP_INV;
                            end else if (cpu_we) begin
                                bus_op_d = OP_WM;
                            end else begin
                                bus_op_d = OP_RM;
                            end
                        end
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        bus_pend_d  = 1'b0;
                        bus_valid_d = 1'b0;
                        if (bus_op_q == OP_INV) begin
                            if (cpu_hit && (line_st_q[cpu_idx] == LN_S)) begin
                                data_d[cpu_idx]    = cpu_wdata;
                                line_st_d[cpu_idx] = LN_M;
                                state_d            = RESP;
                                cpu_done_d         = 1'b1;
                            end else begin
                                // Line was lost to a snoop: IDLE reissues it as a miss.
                                state_d = IDLE;
                            end
                        end else if (line_st_q[cpu_idx] == LN_M) begin
                            state_d     = VICT_WB;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_q[cpu_idx], cpu_idx};
                            mem_wdata_d = data_q[cpu_idx];
                        end else begin
                            state_d    = FILL;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = cpu_addr;
                        end
                    end
                end
                SNP_WB: begin
                    if (mem_done) begin
                        mem_req_d = 1'b0;
                        if (snp_op == OP_RM) begin
                            line_st_d[snp_idx] = LN_S;
                        end else begin
                            line_st_d[snp_idx] = LN_I;
                        end
                        snp_ack_d = 1'b1;
                        state_d   = ret_q;
                    end
                end
                VICT_WB: begin
                    if (mem_done) begin
                        mem_req_d = 1'b0;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    if (!mem_req_q) begin
                        // Entered from VICT_WB: issue the fill after mem_req has dropped.
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu_addr;
                    end else if (mem_ack) begin
                        mem_req_d      = 1'b0;
                        tag_d[cpu_idx] = cpu_tag;
                        if (cpu_we) begin
                            line_st_d[cpu_idx] = LN_M;
                            data_d[cpu_idx]    = cpu_wdata;
                        end else begin
                            line_st_d[cpu_idx] = LN_S;
                            data_d[cpu_idx]    = mem_rdata;
                            cpu_rdata_d        = mem_rdata;
                        end
                        state_d    = RESP;
                        cpu_done_d = 1'b1;
                    end
                end
                RESP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state, coherence states and handshake outputs; reset aborts everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            line_st_q   <= '{default: LN_I};
            bus_pend_q  <= 1'b0;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_valid_q <= 1'b0;
            bus_op_q    <= '0;
            bus_addr_q  <= '0;
            snp_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            line_st_q   <= line_st_d;
            bus_pend_q  <= bus_pend_d;
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_valid_q <= bus_valid_d;
            bus_op_q    <= bus_op_d;
            bus_addr_q  <= bus_addr_d;
            snp_ack_q   <= snp_ack_d;
        end
    end

    // Tag and data storage; contents are meaningless while the line is I, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_valid = bus_valid_q;
    assign bus_op    = bus_op_q;
    assign bus_addr  = bus_addr_q;
    assign snp_ack   = snp_ack_q;

endmodule

// File: tb/tb_msi_snoop_cache.sv
// tb_msi_snoop_cache: table-driven transactions with an event scoreboard,
// plus hand-written sequences for snoop-during-BUS and reset-during-FILL.
module tb_msi_snoop_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_done;
    logic [15:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [15:0] bus_addr;
    logic        bus_ack;
    logic        snp_valid;
    logic [1:0]  snp_op;
    logic [15:0] snp_addr;
    logic        snp_ack;

    always #5 clk = ~clk;

    msi_snoop_cache #(.ADDR_W(16), .DATA_W(16), .INDEX_W(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_ack(bus_ack),
        .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr), .snp_ack(snp_ack)
    );

    localparam int K_BUS = 0, K_MEMW = 1, K_MEMR = 2, K_DONER = 3, K_DONEW = 4, K_SACK = 5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    typedef struct packed {
        logic        snoop;
        logic [1:0]  op;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  lat;
        logic [2:0]  nev;
        ev_t [3:0]   ev;
    } vec_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] mem [bit [15:0]];
    int          mem_delay = 2;
    int          bus_delay = 2;
    bit          bus_hold = 1'b0;
    int          mc = 0;
    int          bc = 0;
    logic        pb = 1'b0;
    logic        pm = 1'b0;
    vec_t        tbl [17];
    ev_t         Z;

    function automatic ev_t E(input int k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = 3'(k);
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic vec_t V(input bit s, input logic [1:0] op, input bit we,
                               input logic [15:0] a, input logic [15:0] wd, input int lat,
                               input int n, input ev_t e0, input ev_t e1, input ev_t e2,
                               input ev_t e3);
        vec_t v;
        v.snoop = s;
        v.op    = op;
        v.we    = we;
        v.addr  = a;
        v.wdata = wd;
        v.lat   = 4'(lat);
        v.nev   = 3'(n);
        v.ev[0] = e0;
        v.ev[1] = e1;
        v.ev[2] = e2;
        v.ev[3] = e3;
        return v;
    endfunction

    task automatic check_ev(input int k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        logic ok;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, expected no event", k, a, d);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == 3'(k)) && (e.addr == a);
            if ((e.kind == 3'(K_BUS)) || (e.kind == 3'(K_MEMW)) || (e.kind == 3'(K_DONER)))
                ok = ok && (e.data == d);
            if (!ok) begin
                bad++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic check_zero(input string nm);
        logic [70:0] o;
        o = {cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             bus_valid, bus_op, bus_addr, snp_ack};
        total++;
        if (o !== 71'h0) begin
            bad++;
            $display("FAIL %s: outputs=%h expected all zero", nm, o);
        end
    endtask

    task automatic check_empty(input string nm);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected events never seen, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  lat;
        bit  got;
        for (int i = 0; i < int'(v.nev); i++) exp_q.push_back(v.ev[i]);
        @(negedge clk);
        if (v.snoop) begin
            snp_valid = 1'b1; snp_op = v.op; snp_addr = v.addr;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            got = v.snoop ? snp_ack : cpu_done;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL vec%0d_timeout: no completion after %0d cycles, expected completion", idx, lat);
        end
        if (v.lat != 0) begin
            total++;
            if (lat != int'(v.lat)) begin
                bad++;
                $display("FAIL vec%0d_latency: got %0d cycles, expected %0d", idx, lat, v.lat);
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
        snp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_empty($sformatf("vec%0d_leftover", idx));
    endtask

    // Event monitor: sampled 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                if (bus_valid && !pb) check_ev(K_BUS, bus_addr, {14'b0, bus_op});
                if (mem_req && !pm) check_ev(mem_we ? K_MEMW : K_MEMR, mem_addr, mem_wdata);
                if (cpu_done) check_ev(cpu_we ? K_DONEW : K_DONER, 16'h0, cpu_rdata);
                if (snp_ack) check_ev(K_SACK, 16'h0, 16'h0);
            end
            pb = bus_valid;
            pm = mem_req;
        end
    end

    // Memory responder.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !reset) begin
                mc++;
                if (mc >= mem_delay) begin
                    mc = 0;
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
                end
            end else begin
                mc = 0;
            end
        end
    end

    // Peer-cache responder for outgoing coherence messages.
    initial begin
        bus_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_valid && !bus_hold && !reset) begin
                bc++;
                if (bc >= bus_delay) begin
                    bc = 0;
                    bus_ack = 1'b1;
                end
            end else begin
                bc = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Z = E(0, 16'h0, 16'h0);
        tbl[0]  = V(0, 2'd0, 0, 16'h0005, 16'h0, 0, 3, E(K_BUS, 16'h0005, 16'd0), E(K_MEMR, 16'h0005, 16'h0), E(K_DONER, 16'h0, 16'h1234), Z);
        tbl[1]  = V(0, 2'd0, 0, 16'h0005, 16'h0, 1, 1, E(K_DONER, 16'h0, 16'h1234), Z, Z, Z);
        tbl[2]  = V(0, 2'd0, 1, 16'h0005, 16'hBEEF, 0, 2, E(K_BUS, 16'h0005, 16'd2), E(K_DONEW, 16'h0, 16'h0), Z, Z);
        tbl[3]  = V(0, 2'd0, 0, 16'h0005, 16'h0, 1, 1, E(K_DONER, 16'h0, 16'hBEEF), Z, Z, Z);
        tbl[4]  = V(0, 2'd0, 0, 16'h0009, 16'h0, 0, 4, E(K_BUS, 16'h0009, 16'd0), E(K_MEMW, 16'h0005, 16'hBEEF), E(K_MEMR, 16'h0009, 16'h0), E(K_DONER, 16'h0, 16'h5678));
        tbl[5]  = V(1, 2'd1, 0, 16'h0009, 16'h0, 1, 1, E(K_SACK, 16'h0, 16'h0), Z, Z, Z);
        tbl[6]  = V(0, 2'd0, 0, 16'h0009, 16'h0, 0, 3, E(K_BUS, 16'h0009, 16'd0), E(K_MEMR, 16'h0009, 16'h0), E(K_DONER, 16'h0, 16'h5678), Z);
        tbl[7]  = V(1, 2'd0, 0, 16'h0005, 16'h0, 1, 1, E(K_SACK, 16'h0, 16'h0), Z, Z, Z);
        tbl[8]  = V(0, 2'd0, 0, 16'h0009, 16'h0, 1, 1, E(K_DONER, 16'h0, 16'h5678), Z, Z, Z);
        tbl[9]  = V(0, 2'd0, 1, 16'h0006, 16'h6666, 0, 3, E(K_BUS, 16'h0006, 16'd1), E(K_MEMR, 16'h0006, 16'h0), E(K_DONEW, 16'h0, 16'h0), Z);
        tbl[10] = V(1, 2'd0, 0, 16'h0006, 16'h0, 0, 2, E(K_MEMW, 16'h0006, 16'h6666), E(K_SACK, 16'h0, 16'h0), Z, Z);
        tbl[11] = V(0, 2'd0, 0, 16'h0006, 16'h0, 1, 1, E(K_DONER, 16'h0, 16'h6666), Z, Z, Z);
        tbl[12] = V(1, 2'd2, 0, 16'h0006, 16'h0, 1, 1, E(K_SACK, 16'h0, 16'h0), Z, Z, Z);
        tbl[13] = V(0, 2'd0, 0, 16'h0006, 16'h0, 0, 3, E(K_BUS, 16'h0006, 16'd0), E(K_MEMR, 16'h0006, 16'h0), E(K_DONER, 16'h0, 16'h6666), Z);
        tbl[14] = V(0, 2'd0, 1, 16'h0006, 16'h7777, 0, 2, E(K_BUS, 16'h0006, 16'd2), E(K_DONEW, 16'h0, 16'h0), Z, Z);
        tbl[15] = V(0, 2'd0, 1, 16'h0006, 16'h8888, 1, 1, E(K_DONEW, 16'h0, 16'h0), Z, Z, Z);
        tbl[16] = V(0, 2'd0, 0, 16'h0006, 16'h0, 1, 1, E(K_DONER, 16'h0, 16'h8888), Z, Z, Z);

        mem[16'h0005] = 16'h1234;
        mem[16'h0009] = 16'h5678;
        mem[16'h000A] = 16'h0AAA;
        mem[16'h0006] = 16'h0666;
        mem[16'h000D] = 16'h0DDD;

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        snp_valid = 1'b0; snp_op = 2'd0; snp_addr = 16'h0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

        // Snoop RM to a dirty line while a read miss waits for bus_ack.
        exp_q.push_back(E(K_BUS, 16'h000A, 16'd0));
        exp_q.push_back(E(K_MEMW, 16'h0006, 16'h8888));
        exp_q.push_back(E(K_SACK, 16'h0, 16'h0));
        bus_hold = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h000A;
        n = 0;
        while (!bus_valid && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (!bus_valid) begin bad++; $display("FAIL snpbus_wait_bus: bus_valid=%b, expected 1", bus_valid); end
        @(negedge clk);
        snp_valid = 1'b1; snp_op = 2'd0; snp_addr = 16'h0006;
        n = 0;
        while (!snp_ack && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (!snp_ack) begin bad++; $display("FAIL snpbus_ack: snp_ack=%b, expected 1", snp_ack); end
        @(negedge clk);
        snp_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (bus_valid !== 1'b1) begin bad++; $display("FAIL snpbus_still_bus: bus_valid=%b, expected 1", bus_valid); end
        check_empty("snpbus_snoop_events");
        exp_q.push_back(E(K_MEMR, 16'h000A, 16'h0));
        exp_q.push_back(E(K_DONER, 16'h0, 16'h0AAA));
        bus_hold = 1'b0;
        n = 0;
        while (!cpu_done && n < 100) begin @(posedge clk); #1; n++; end
        total++;
        if (!cpu_done) begin bad++; $display("FAIL snpbus_done: cpu_done=%b, expected 1", cpu_done); end
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check_empty("snpbus_leftover");

        // Reset asserted while the fill of 0x000D is outstanding.
        mem_delay = 1000;
        exp_q.push_back(E(K_BUS, 16'h000D, 16'd0));
        exp_q.push_back(E(K_MEMR, 16'h000D, 16'h0));
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h000D;
        n = 0;
        while (!mem_req && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (!mem_req) begin bad++; $display("FAIL rstfill_mem_req: mem_req=%b, expected 1", mem_req); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero("reset_mid_fill");
        cpu_req = 1'b0;
        check_empty("rstfill_events");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_delay = 2;
        repeat (2) @(negedge clk);
        run_vec(V(0, 2'd0, 0, 16'h0009, 16'h0, 0, 3, E(K_BUS, 16'h0009, 16'd0),
                  E(K_MEMR, 16'h0009, 16'h0), E(K_DONER, 16'h0, 16'h5678), Z), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
